// File: rtl/nios2_jtag_dbg_pkg.sv
// Shared definitions for the Nios II JTAG debug host sequencer.
package nios2_jtag_dbg_pkg;

  // Default debug DR scan length.
  localparam int unsigned DBG_DR_WIDTH = 38;

  // Virtual IR codes understood by the debug module.
  localparam logic [1:0] IR_OCIMEM    = 2'd0;
  localparam logic [1:0] IR_TRACEMEM  = 2'd1;
  localparam logic [1:0] IR_BREAK     = 2'd2;
  localparam logic [1:0] IR_TRACECTRL = 2'd3;

  // Sequencer states.
  typedef logic [2:0] seq_state_t;
  localparam seq_state_t StIdle    = 3'd0;
  localparam seq_state_t StUir     = 3'd1;
  localparam seq_state_t StCdr     = 3'd2;
  localparam seq_state_t StSdr     = 3'd3;
  localparam seq_state_t StUdr     = 3'd4;
  localparam seq_state_t StRtiHold = 3'd5;
  localparam seq_state_t StResp    = 3'd6;

  // tck toggles in every state that scans or holds run-test-idle.
  function automatic logic state_runs_tck(input seq_state_t s);
    return (s != StIdle) && (s != StResp);
  endfunction

endpackage

// File: rtl/nios2_jtag_debug_host_sequencer_if.sv
// Command/response handshake bundle between a debug host and the sequencer.
interface nios2_jtag_debug_host_sequencer_if
  import nios2_jtag_dbg_pkg::*;
#(
  parameter int unsigned DR_WIDTH = DBG_DR_WIDTH
);
  logic                cmd_valid;
  logic                cmd_ready;
  logic [1:0]          cmd_ir;
  logic                cmd_skip_ir;
  logic [DR_WIDTH-1:0] cmd_dr;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [DR_WIDTH-1:0] rsp_dr;
  logic [1:0]          rsp_ir_out;

  // Host side: issues commands, consumes responses.
  modport master (
    output cmd_valid, cmd_ir, cmd_skip_ir, cmd_dr, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_dr, rsp_ir_out
  );

  // Sequencer side.
  modport slave (
    input  cmd_valid, cmd_ir, cmd_skip_ir, cmd_dr, rsp_ready,
    output cmd_ready, rsp_valid, rsp_dr, rsp_ir_out
  );
endinterface

// File: rtl/nios2_jtag_tck_gen.sv
// Test-clock generator: divides clk by 2*TCK_HALF while run_i is high.
// tck is low for the first half of each period and high for the second.
module nios2_jtag_tck_gen
  import nios2_jtag_dbg_pkg::*;
#(
  parameter int unsigned TCK_HALF = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic run_i,
  output logic tck_o,
  output logic period_start_o,
  output logic rise_o,
  output logic period_end_o
);

  localparam int unsigned PhW = $clog2(2 * TCK_HALF);
  localparam logic [PhW-1:0] PhLast = PhW'(2 * TCK_HALF - 1);
  localparam logic [PhW-1:0] PhHigh = PhW'(TCK_HALF);
  localparam logic [PhW-1:0] PhRise = PhW'(TCK_HALF - 1);

  logic [PhW-1:0] ph_q, ph_d;
  logic           tck_q, tck_d;

  // Phase counter wraps every period; tck is registered so it never glitches.
  always_comb begin
    ph_d  = '0;
    if (run_i) begin
      ph_d = (ph_q == PhLast) ? '0 : ph_q + 1'b1;
    end
    tck_d = run_i && (ph_d >= PhHigh);
  end

  // Phase and tck state.
  always_ff @(posedge clk) begin
    if (reset) begin
      ph_q  <= '0;
      tck_q <= 1'b0;
    end else begin
      ph_q  <= ph_d;
      tck_q <= tck_d;
    end
  end

  assign tck_o          = tck_q;
  assign period_start_o = run_i && (ph_q == '0);
  // Asserted in the cycle whose closing edge raises tck.
  assign rise_o         = run_i && (ph_q == PhRise);
  assign period_end_o   = run_i && (ph_q == PhLast);

endmodule

// File: rtl/nios2_jtag_debug_host_sequencer.sv
// Host-side virtual-JTAG initiator: each accepted command becomes one
// IR-select (optional) + DR-scan transaction, captured DR returned as a response.
module nios2_jtag_debug_host_sequencer
  import nios2_jtag_dbg_pkg::*;
#(
  parameter int unsigned DR_WIDTH   = DBG_DR_WIDTH,
  parameter int unsigned TCK_HALF   = 2,
  parameter int unsigned RTI_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  nios2_jtag_debug_host_sequencer_if.slave host,
  output logic       vji_tck,
  output logic       vji_tdi,
  input  logic       vji_tdo,
  output logic [1:0] vji_ir_in,
  input  logic [1:0] vji_ir_out,
  output logic       vji_uir,
  output logic       vji_cdr,
  output logic       vji_sdr,
  output logic       vji_udr,
  output logic       vji_rti
);

  localparam int unsigned CntMax = (DR_WIDTH > RTI_CYCLES) ? DR_WIDTH : RTI_CYCLES;
  localparam int unsigned CntW   = $clog2(CntMax + 1);
  localparam logic [CntW-1:0] BitLast = CntW'(DR_WIDTH - 1);
  localparam logic [CntW-1:0] RtiLast = CntW'(RTI_CYCLES - 1);

  seq_state_t          state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [DR_WIDTH-1:0] sh_q, sh_d;
  logic [1:0]          cmd_ir_q, cmd_ir_d;
  logic [1:0]          ir_q, ir_d;
  logic [DR_WIDTH-1:0] rsp_dr_q, rsp_dr_d;
  logic [1:0]          rsp_ir_out_q, rsp_ir_out_d;

  logic run, period_start, rise, period_end;

  assign run = state_runs_tck(state_q);

  nios2_jtag_tck_gen #(
    .TCK_HALF (TCK_HALF)
  ) u_tck_gen (
    .clk            (clk),
    .reset          (reset),
    .run_i          (run),
    .tck_o          (vji_tck),
    .period_start_o (period_start),
    .rise_o         (rise),
    .period_end_o   (period_end)
  );

  // Transaction sequencing; states advance only at period boundaries.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    sh_d         = sh_q;
    cmd_ir_d     = cmd_ir_q;
    ir_d         = ir_q;
    rsp_dr_d     = rsp_dr_q;
    rsp_ir_out_d = rsp_ir_out_q;
    case (state_q)
      StIdle: begin
        if (host.cmd_valid) begin
          cmd_ir_d = host.cmd_ir;
          sh_d     = host.cmd_dr;
          cnt_d    = '0;
          state_d  = host.cmd_skip_ir ? StCdr : StUir;
        end
      end
      StUir: begin
        // ir_in already shows cmd_ir via the output mux; make it persistent.
        if (period_start) ir_d = cmd_ir_q;
        if (rise) rsp_ir_out_d = vji_ir_out;
        if (period_end) state_d = StCdr;
      end
      StCdr: begin
        if (period_end) begin
          state_d = StSdr;
          cnt_d   = '0;
        end
      end
      StSdr: begin
        // LSB-first capture: bit k ends up in rsp_dr[k] after DR_WIDTH shifts.
        if (rise) rsp_dr_d = {vji_tdo, rsp_dr_q[DR_WIDTH-1:1]};
        if (period_end) begin
          sh_d = sh_q >> 1;
          if (cnt_q == BitLast) begin
            state_d = StUdr;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      StUdr: begin
        if (period_end) begin
          state_d = StRtiHold;
          cnt_d   = '0;
        end
      end
      StRtiHold: begin
        if (period_end) begin
          if (cnt_q == RtiLast) state_d = StResp;
          else                  cnt_d   = cnt_q + 1'b1;
        end
      end
      StResp: begin
        if (host.rsp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Sequencer state; reset wipes any in-flight transaction.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      sh_q         <= '0;
      cmd_ir_q     <= '0;
      ir_q         <= '0;
      rsp_dr_q     <= '0;
      rsp_ir_out_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      sh_q         <= sh_d;
      cmd_ir_q     <= cmd_ir_d;
      ir_q         <= ir_d;
      rsp_dr_q     <= rsp_dr_d;
      rsp_ir_out_q <= rsp_ir_out_d;
    end
  end

  // Strobes decode straight from state, so they only move at period starts.
  always_comb begin
    vji_uir   = (state_q == StUir);
    vji_cdr   = (state_q == StCdr);
    vji_sdr   = (state_q == StSdr);
    vji_udr   = (state_q == StUdr);
    vji_rti   = (state_q == StIdle) || (state_q == StRtiHold) || (state_q == StResp);
    vji_tdi   = (state_q == StSdr) && sh_q[0];
    vji_ir_in = (state_q == StUir) ? cmd_ir_q : ir_q;
  end

  assign host.cmd_ready  = (state_q == StIdle);
  assign host.rsp_valid  = (state_q == StResp);
  assign host.rsp_dr     = rsp_dr_q;
  assign host.rsp_ir_out = rsp_ir_out_q;

endmodule

// File: tb/tb_nios2_jtag_debug_host_sequencer.sv
// Directed bench: two sequencers (TCK_HALF=2 and TCK_HALF=1) against a
// behavioural virtual-JTAG target shift register.
module tb_nios2_jtag_debug_host_sequencer;
  import nios2_jtag_dbg_pkg::*;

  localparam int unsigned W = 38;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  nios2_jtag_debug_host_sequencer_if #(.DR_WIDTH(W)) h0 ();
  nios2_jtag_debug_host_sequencer_if #(.DR_WIDTH(W)) h1 ();

  logic       tck0, tdi0, tdo0, uir0, cdr0, sdr0, udr0, rti0;
  logic [1:0] ir_in0, ir_out0;
  logic       tck1, tdi1, tdo1, uir1, cdr1, sdr1, udr1, rti1;
  logic [1:0] ir_in1, ir_out1;

  nios2_jtag_debug_host_sequencer #(
    .DR_WIDTH (W), .TCK_HALF (2), .RTI_CYCLES (4)
  ) dut0 (
    .clk (clk), .reset (reset), .host (h0),
    .vji_tck (tck0), .vji_tdi (tdi0), .vji_tdo (tdo0),
    .vji_ir_in (ir_in0), .vji_ir_out (ir_out0),
    .vji_uir (uir0), .vji_cdr (cdr0), .vji_sdr (sdr0), .vji_udr (udr0), .vji_rti (rti0)
  );

  nios2_jtag_debug_host_sequencer #(
    .DR_WIDTH (W), .TCK_HALF (1), .RTI_CYCLES (4)
  ) dut1 (
    .clk (clk), .reset (reset), .host (h1),
    .vji_tck (tck1), .vji_tdi (tdi1), .vji_tdo (tdo1),
    .vji_ir_in (ir_in1), .vji_ir_out (ir_out1),
    .vji_uir (uir1), .vji_cdr (cdr1), .vji_sdr (sdr1), .vji_udr (udr1), .vji_rti (rti1)
  );

  // Target models: sr <= {tdi, sr[W-1:1]} on each sdr tck rise, tdo = sr[0].
  // A rise is recognised one clk late, which still precedes the next DUT sample.
  logic [W-1:0] m0_sr, m0_load_val, m0_udr_sr, m1_sr, m1_load_val, m1_udr_sr;
  logic         m0_load = 1'b0, m1_load = 1'b0, m0_tck_prev, m1_tck_prev;
  logic [1:0]   m0_ir_out, m1_ir_out, m0_uir_ir, m1_uir_ir;
  int           m0_sdr_n = 0, m0_uir_n = 0, m1_sdr_n = 0, m1_uir_n = 0;

  assign tdo0    = m0_sr[0];
  assign ir_out0 = m0_ir_out;
  assign tdo1    = m1_sr[0];
  assign ir_out1 = m1_ir_out;

  always @(posedge clk) begin
    m0_tck_prev <= tck0;
    if (m0_load) m0_sr <= m0_load_val;
    else if (tck0 && !m0_tck_prev) begin
      if (sdr0) begin
        m0_sr    <= {tdi0, m0_sr[W-1:1]};
        m0_sdr_n <= m0_sdr_n + 1;
      end
      if (uir0) begin
        m0_uir_n  <= m0_uir_n + 1;
        m0_uir_ir <= ir_in0;
      end
      if (udr0) m0_udr_sr <= m0_sr;
    end
  end

  always @(posedge clk) begin
    m1_tck_prev <= tck1;
    if (m1_load) m1_sr <= m1_load_val;
    else if (tck1 && !m1_tck_prev) begin
      if (sdr1) begin
        m1_sr    <= {tdi1, m1_sr[W-1:1]};
        m1_sdr_n <= m1_sdr_n + 1;
      end
      if (uir1) begin
        m1_uir_n  <= m1_uir_n + 1;
        m1_uir_ir <= ir_in1;
      end
      if (udr1) m1_udr_sr <= m1_sr;
    end
  end

  // Protocol watch: exclusive strobes, and no tdi/ir/strobe change while tck is high.
  int         prot0_err = 0, prot1_err = 0;
  logic [7:0] p0_prev, p1_prev;
  always @(negedge clk) begin
    if (!reset) begin
      if (!$onehot0({uir0, cdr0, sdr0, udr0}) || (rti0 && (uir0 | cdr0 | sdr0 | udr0)))
        prot0_err <= prot0_err + 1;
      else if (tck0 && ({tdi0, ir_in0, uir0, cdr0, sdr0, udr0, rti0} != p0_prev))
        prot0_err <= prot0_err + 1;
    end
    p0_prev <= {tdi0, ir_in0, uir0, cdr0, sdr0, udr0, rti0};
  end
  always @(negedge clk) begin
    if (!reset) begin
      if (!$onehot0({uir1, cdr1, sdr1, udr1}) || (rti1 && (uir1 | cdr1 | sdr1 | udr1)))
        prot1_err <= prot1_err + 1;
      else if (tck1 && ({tdi1, ir_in1, uir1, cdr1, sdr1, udr1, rti1} != p1_prev))
        prot1_err <= prot1_err + 1;
    end
    p1_prev <= {tdi1, ir_in1, uir1, cdr1, sdr1, udr1, rti1};
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic f_cmd_ready(input bit sel);
    return sel ? h1.cmd_ready : h0.cmd_ready;
  endfunction
  function automatic logic f_rsp_valid(input bit sel);
    return sel ? h1.rsp_valid : h0.rsp_valid;
  endfunction
  function automatic logic [W-1:0] f_rsp_dr(input bit sel);
    return sel ? h1.rsp_dr : h0.rsp_dr;
  endfunction
  function automatic logic [1:0] f_rsp_ir(input bit sel);
    return sel ? h1.rsp_ir_out : h0.rsp_ir_out;
  endfunction

  task automatic drive_cmd(input bit sel, input logic v, input logic [1:0] ir,
                           input logic skip, input logic [W-1:0] dr);
    if (sel) begin
      h1.cmd_valid = v; h1.cmd_ir = ir; h1.cmd_skip_ir = skip; h1.cmd_dr = dr;
    end else begin
      h0.cmd_valid = v; h0.cmd_ir = ir; h0.cmd_skip_ir = skip; h0.cmd_dr = dr;
    end
  endtask

  task automatic drive_rsp_ready(input bit sel, input logic v);
    if (sel) h1.rsp_ready = v;
    else     h0.rsp_ready = v;
  endtask

  task automatic load_sr(input bit sel, input logic [W-1:0] val);
    @(negedge clk);
    if (sel) begin m1_load = 1'b1; m1_load_val = val; end
    else     begin m0_load = 1'b1; m0_load_val = val; end
    @(negedge clk);
    m0_load = 1'b0;
    m1_load = 1'b0;
  endtask

  // One full transaction; optional response backpressure and ignored-command pokes.
  task automatic run_txn(input bit sel, input logic [1:0] ir, input logic skip,
                         input logic [W-1:0] dr, input int hold, input bit poke,
                         output int lat, output logic [W-1:0] dr_got,
                         output logic [1:0] ir_got);
    int n;
    int acc;
    int bad;
    lat    = -1;
    dr_got = '0;
    ir_got = '0;
    n      = 0;
    @(negedge clk);
    while (!f_cmd_ready(sel) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!f_cmd_ready(sel)) begin
      check_eq("accept_timeout", 64'd0, 64'd1);
      return;
    end
    drive_cmd(sel, 1'b1, ir, skip, dr);
    acc = int'(cyc);
    @(negedge clk);
    drive_cmd(sel, 1'b0, 2'd0, 1'b0, '0);
    n = 0;
    while (!f_rsp_valid(sel) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!f_rsp_valid(sel)) begin
      check_eq("rsp_timeout", 64'd0, 64'd1);
      return;
    end
    lat    = int'(cyc) - acc;
    dr_got = f_rsp_dr(sel);
    ir_got = f_rsp_ir(sel);
    bad    = 0;
    for (int i = 0; i < hold; i++) begin
      if (poke) drive_cmd(sel, 1'b1, IR_OCIMEM, 1'b0, '1);
      @(negedge clk);
      if (!f_rsp_valid(sel) || f_cmd_ready(sel) || (f_rsp_dr(sel) !== dr_got)) bad++;
    end
    if (hold > 0) check_eq("hold_stable", 64'(bad), 64'd0);
    drive_cmd(sel, 1'b0, 2'd0, 1'b0, '0);
    drive_rsp_ready(sel, 1'b1);
    @(negedge clk);
    drive_rsp_ready(sel, 1'b0);
    check_eq("ready_after_hs", 64'(f_cmd_ready(sel)), 64'd1);
    check_eq("valid_after_hs", 64'(f_rsp_valid(sel)), 64'd0);
  endtask

  initial begin
    int           lat;
    int           base_sdr, base_uir, n, seen;
    logic [W-1:0] dr_got;
    logic [1:0]   ir_got;

    reset = 1'b1;
    drive_cmd(1'b0, 1'b0, 2'd0, 1'b0, '0);
    drive_cmd(1'b1, 1'b0, 2'd0, 1'b0, '0);
    h0.rsp_ready = 1'b0;
    h1.rsp_ready = 1'b0;
    m0_ir_out = 2'b10;
    m1_ir_out = 2'b10;
    repeat (3) @(negedge clk);

    // Reset values.
    check_eq("rst_tck", 64'(tck0), 64'd0);
    check_eq("rst_tdi", 64'(tdi0), 64'd0);
    check_eq("rst_ir_in", 64'(ir_in0), 64'd0);
    check_eq("rst_strobes", 64'({uir0, cdr0, sdr0, udr0}), 64'd0);
    check_eq("rst_rti", 64'(rti0), 64'd1);
    check_eq("rst_cmd_ready", 64'(h0.cmd_ready), 64'd1);
    check_eq("rst_rsp_valid", 64'(h0.rsp_valid), 64'd0);
    check_eq("rst_rsp_dr", 64'(h0.rsp_dr), 64'd0);
    check_eq("rst_rsp_ir_out", 64'(h0.rsp_ir_out), 64'd0);
    check_eq("rst1_state", 64'({tck1, rti1, h1.cmd_ready, h1.rsp_valid}), 64'b0110);
    reset = 1'b0;

    // Full scan, TCK_HALF=2: P = 1+1+38+1+4 = 45, latency 1+45*4.
    load_sr(1'b0, 38'h3F_0000_0001);
    base_sdr = m0_sdr_n;
    base_uir = m0_uir_n;
    run_txn(1'b0, IR_BREAK, 1'b0, 38'h25_5555_5555, 0, 1'b0, lat, dr_got, ir_got);
    check_eq("full_latency", 64'(lat), 64'd181);
    check_eq("full_rsp_dr", 64'(dr_got), 64'(38'h3F_0000_0001));
    check_eq("full_rsp_ir_out", 64'(ir_got), 64'b10);
    check_eq("full_sdr_rises", 64'(m0_sdr_n - base_sdr), 64'd38);
    check_eq("full_uir_rises", 64'(m0_uir_n - base_uir), 64'd1);
    check_eq("full_uir_ir_in", 64'(m0_uir_ir), 64'(IR_BREAK));
    check_eq("full_sr_at_udr", 64'(m0_udr_sr), 64'(38'h25_5555_5555));
    check_eq("full_ir_persist", 64'(ir_in0), 64'(IR_BREAK));

    // skip_ir: no UIR, ir_in keeps 2, latency 1+44*4.
    base_sdr = m0_sdr_n;
    base_uir = m0_uir_n;
    run_txn(1'b0, IR_TRACEMEM, 1'b1, 38'h00_1234_5678, 0, 1'b0, lat, dr_got, ir_got);
    check_eq("skip_latency", 64'(lat), 64'd177);
    check_eq("skip_rsp_dr", 64'(dr_got), 64'(38'h25_5555_5555));
    check_eq("skip_uir_rises", 64'(m0_uir_n - base_uir), 64'd0);
    check_eq("skip_sdr_rises", 64'(m0_sdr_n - base_sdr), 64'd38);
    check_eq("skip_ir_in", 64'(ir_in0), 64'(IR_BREAK));

    // Backpressure with commands offered (and ignored) while the response waits.
    base_uir = m0_uir_n;
    run_txn(1'b0, IR_TRACECTRL, 1'b0, 38'h0A_BCDE_F012, 10, 1'b1, lat, dr_got, ir_got);
    check_eq("bp_latency", 64'(lat), 64'd181);
    check_eq("bp_rsp_dr", 64'(dr_got), 64'(38'h00_1234_5678));
    check_eq("bp_uir_rises", 64'(m0_uir_n - base_uir), 64'd1);
    check_eq("bp_ir_in", 64'(ir_in0), 64'(IR_TRACECTRL));
    run_txn(1'b0, IR_OCIMEM, 1'b0, 38'h3A_5A5A_0F0F, 0, 1'b0, lat, dr_got, ir_got);
    check_eq("b2b_rsp_dr", 64'(dr_got), 64'(38'h0A_BCDE_F012));
    check_eq("b2b_ir_in", 64'(ir_in0), 64'(IR_OCIMEM));

    // Reset in the middle of the DR scan.
    @(negedge clk);
    drive_cmd(1'b0, 1'b1, IR_BREAK, 1'b0, 38'h15_5555_AAAA);
    base_sdr = m0_sdr_n;
    @(negedge clk);
    drive_cmd(1'b0, 1'b0, 2'd0, 1'b0, '0);
    n = 0;
    while ((m0_sdr_n - base_sdr) < 17 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check_eq("mid_reached_bit17", 64'(m0_sdr_n - base_sdr), 64'd17);
    reset = 1'b1;
    @(negedge clk);
    check_eq("mid_tck", 64'(tck0), 64'd0);
    check_eq("mid_sdr", 64'(sdr0), 64'd0);
    check_eq("mid_rti", 64'(rti0), 64'd1);
    check_eq("mid_cmd_ready", 64'(h0.cmd_ready), 64'd1);
    check_eq("mid_ir_in", 64'(ir_in0), 64'd0);
    reset = 1'b0;
    seen = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (h0.rsp_valid) seen++;
    end
    check_eq("mid_no_rsp", 64'(seen), 64'd0);

    load_sr(1'b0, 38'h2A_AAAA_5555);
    m0_ir_out = 2'b01;
    run_txn(1'b0, IR_TRACEMEM, 1'b0, 38'h11_2233_4455, 0, 1'b0, lat, dr_got, ir_got);
    check_eq("post_latency", 64'(lat), 64'd181);
    check_eq("post_rsp_dr", 64'(dr_got), 64'(38'h2A_AAAA_5555));
    check_eq("post_rsp_ir_out", 64'(ir_got), 64'b01);
    check_eq("post_sr_at_udr", 64'(m0_udr_sr), 64'(38'h11_2233_4455));

    // Full scan with TCK_HALF=1: latency 1+45*2.
    load_sr(1'b1, 38'h3F_0000_0001);
    base_sdr = m1_sdr_n;
    run_txn(1'b1, IR_BREAK, 1'b0, 38'h25_5555_5555, 0, 1'b0, lat, dr_got, ir_got);
    check_eq("h1_latency", 64'(lat), 64'd91);
    check_eq("h1_rsp_dr", 64'(dr_got), 64'(38'h3F_0000_0001));
    check_eq("h1_rsp_ir_out", 64'(ir_got), 64'b10);
    check_eq("h1_sdr_rises", 64'(m1_sdr_n - base_sdr), 64'd38);
    check_eq("h1_uir_ir_in", 64'(m1_uir_ir), 64'(IR_BREAK));
    check_eq("h1_sr_at_udr", 64'(m1_udr_sr), 64'(38'h25_5555_5555));

    repeat (2) @(negedge clk);
    check_eq("protocol_h2", 64'(prot0_err), 64'd0);
    check_eq("protocol_h1", 64'(prot1_err), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
